bike_meter_ctrl: RTL and testbench
==================================

# bike_meter_ctrl

Front-panel controller and measurement sequencer for the bicycle meter. It generates the square-wave measurement gate that clocks the distance/speed block, and issues that block's active-low clear. It holds the wheel circumference setting and selects which quantity the display shows. Three raw push-buttons are debounced and decoded into a four-state mode machine.

## Interface
Parameters:
- GATE_CYCLES, 1000: clk cycles per gate half-period; gate period = 2*GATE_CYCLES.
- DEB_CYCLES, 20: consecutive stable cycles required to accept a key level change.
- CIRC_MIN, 1: lowest circumference setting.
- CIRC_MAX, 15: highest circumference setting (≤15).
- CIRC_INIT, 8: circumference after reset.

Ports:
- clk  in  1: system clock; all logic on rising edge.
- rst  in  1: asynchronous, active-high reset.
- key_mode  in  1: raw mode button, active-high, asynchronous, may bounce.
- key_up  in  1: raw increment button, same properties.
- key_clr  in  1: raw clear button, same properties.
- gate  out  1: measurement gate to the distance/speed block clock input.
- clr_n  out  1: active-low clear to the distance/speed block.
- circle  out  4: circumference setting to the distance/speed block.
- disp_sel  out  2: display source; 0 = distance, 1 = speed, 2 = circumference; 3 never driven.
- setting  out  1: high while in SET_CIRC; drives the set-mode indicator LED.

## Operation
- Key path, identical per key:
  - 2-flop synchronizer.
  - Debounce counter: increments while the synchronized value differs from the debounced level, and clears to 0 when they match.
  - When a mismatch is seen with counter = DEB_CYCLES-1, the debounced level toggles and the counter clears.
  - A debounced 0→1 transition produces a registered one-cycle press pulse.
  - Releases produce no pulse.
- Gate generator:
  - Free-running counter 0..GATE_CYCLES-1.
  - gate toggles when the counter wraps.
  - Runs in every state. It is never stopped or restarted, except by rst.
- FSM states: DIST, SPEED, SET_CIRC, CLEAR. Reset state is DIST.
  - DIST: mode → SPEED; clr → CLEAR (return target DIST); up ignored.
  - SPEED: mode → SET_CIRC; clr → CLEAR (return target SPEED); up ignored.
  - SET_CIRC:
    - up → circle+1; from CIRC_MAX it wraps to CIRC_MIN.
    - mode → DIST.
    - clr ignored.
  - CLEAR:
    - clr_n held low for exactly 2*GATE_CYCLES clk cycles, which guarantees at least one rising gate edge while clear is asserted.
    - Then return to the saved state.
    - All presses during CLEAR are discarded, not queued.
- Simultaneous press pulses in one cycle: priority clr > mode > up. Only the highest is acted on; the others are dropped.
- Outputs are registered:
  - disp_sel = 0 in DIST, 1 in SPEED, 2 in SET_CIRC.
  - In CLEAR, disp_sel holds the value of the state that was left.
  - setting = 1 only in SET_CIRC.
- circle changes only in SET_CIRC and is not affected by CLEAR.

## Timing
- Reset values:
  - gate = 0, gate counter = 0.
  - clr_n = 1, circle = CIRC_INIT, disp_sel = 0, setting = 0.
  - State DIST; debounced levels 0; debounce counters 0.
- Gate edges: after rst deasserts, gate first rises on the GATE_CYCLES-th clk edge, then toggles every GATE_CYCLES edges.
- Key latency, counting clean raw rise as edge 0:
  - Synchronized value = 1 at edge 2.
  - Debounced level = 1 at edge DEB_CYCLES+2.
  - Press pulse at edge DEB_CYCLES+3.
  - FSM outputs (disp_sel, setting, circle, clr_n) update at edge DEB_CYCLES+4.
- Bounce shorter than DEB_CYCLES cycles produces no pulse. A key held for any duration yields exactly one pulse.
- CLEAR: clr_n falls on the edge where the state enters CLEAR. It rises exactly 2*GATE_CYCLES edges later, on the same edge the state returns.
- rst mid-operation (any state, including CLEAR):
  - All outputs return to reset values immediately, without waiting for a clock.
  - Any pending press is lost.

## Test plan
- Reset, GATE_CYCLES=4: after rst release, gate = 0,0,0,1,1,1,1,0… (rises at edge 4, falls at edge 8). clr_n=1, circle=8, disp_sel=0.
- Mode cycling, DEB_CYCLES=3: three clean key_mode presses, each held 10 cycles → disp_sel 0→1→2(setting=1)→0. Each change occurs 7 edges after the raw rise.
- Bounce: key_mode toggled with 2-cycle pulses, then held high 10 cycles (DEB_CYCLES=3) → exactly one disp_sel change.
- Circumference, CIRC_INIT=14, CIRC_MAX=15, CIRC_MIN=1: in SET_CIRC, press up 3 times → circle 15, 1, 2.
  - up pressed in DIST → circle unchanged.
- Clear, GATE_CYCLES=4, from SPEED:
  - clr press → clr_n low for exactly 8 cycles, with at least one gate rise inside.
  - disp_sel stays 1; mode pressed during CLEAR is ignored; state returns to SPEED.
- Priority and reset:
  - mode and clr released from bounce in the same cycle in DIST → CLEAR taken, mode dropped.
  - rst asserted halfway through CLEAR → clr_n=1 and disp_sel=0 asynchronously, circle=CIRC_INIT.

Source files
------------

// File: rtl/bike_meter_ctrl.sv
// Bicycle meter front panel: key debounce, measurement gate generator
// and the DIST/SPEED/SET_CIRC/CLEAR mode sequencer.
module bike_meter_ctrl #(
  parameter int GATE_CYCLES = 1000,
  parameter int DEB_CYCLES  = 20,
  parameter int CIRC_MIN    = 1,
  parameter int CIRC_MAX    = 15,
  parameter int CIRC_INIT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_clr,
  output logic       gate,
  output logic       clr_n,
  output logic [3:0] circle,
  output logic [1:0] disp_sel,
  output logic       setting
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int CW = $clog2(2 * GATE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_DIST, S_SPEED, S_SET, S_CLEAR
  } state_t;

  logic [2:0]         raw;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         lvl_q, lvl_dly_q, press_q;
  logic [2:0][DW-1:0] deb_cnt_q;

  assign raw = {key_clr, key_up, key_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      press_q   <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      lvl_dly_q <= lvl_q;
      press_q   <= lvl_q & ~lvl_dly_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != lvl_q[i]) begin
          if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
            lvl_q[i]     <= ~lvl_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic          p_mode, p_up, p_clr;
  assign p_mode = press_q[0];
  assign p_up   = press_q[1];
  assign p_clr  = press_q[2];

  // Free-running gate; never restarted by mode changes or CLEAR
  logic [GW-1:0] gcnt_q;
  logic          gate_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '0;
      gate_q <= 1'b0;
    end else if (gcnt_q == GW'(GATE_CYCLES - 1)) begin
      gcnt_q <= '0;
      gate_q <= ~gate_q;
    end else begin
      gcnt_q <= gcnt_q + 1'b1;
    end
  end

  state_t        state_q, ret_q;
  logic [CW-1:0] ccnt_q;
  logic          clr_n_q, set_q;
  logic [3:0]    circle_q;
  logic [1:0]    disp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_DIST;
      ret_q    <= S_DIST;
      ccnt_q   <= '0;
      clr_n_q  <= 1'b1;
      set_q    <= 1'b0;
      circle_q <= 4'(CIRC_INIT);
      disp_q   <= 2'd0;
    end else begin
      unique case (state_q)
        S_DIST: begin
          if (p_clr) begin
            state_q <= S_CLEAR;
            ret_q   <= S_DIST;
            ccnt_q  <= '0;
            clr_n_q <= 1'b0;
          end else if (p_mode) begin
            state_q <= S_SPEED;
            disp_q  <= 2'd1;
          end
        end
        S_SPEED: begin
          if (p_clr) begin
            state_q <= S_CLEAR;
            ret_q   <= S_SPEED;
            ccnt_q  <= '0;
            clr_n_q <= 1'b0;
          end else if (p_mode) begin
            state_q <= S_SET;
            disp_q  <= 2'd2;
            set_q   <= 1'b1;
          end
        end
        S_SET: begin
          if (p_mode) begin
            state_q <= S_DIST;
            disp_q  <= 2'd0;
            set_q   <= 1'b0;
          end else if (p_up) begin
            circle_q <= (circle_q >= 4'(CIRC_MAX)) ?
                        4'(CIRC_MIN) : circle_q + 4'd1;
          end
        end
        S_CLEAR: begin
          // presses are dropped here; disp_sel keeps the left state's value
          if (ccnt_q == CW'(2 * GATE_CYCLES - 1)) begin
            state_q <= ret_q;
            clr_n_q <= 1'b1;
          end else begin
            ccnt_q <= ccnt_q + 1'b1;
          end
        end
        default: state_q <= S_DIST;
      endcase
    end
  end

  assign gate     = gate_q;
  assign clr_n    = clr_n_q;
  assign circle   = circle_q;
  assign disp_sel = disp_q;
  assign setting  = set_q;

endmodule

// File: tb/tb_bike_meter_ctrl.sv
// Directed bench for bike_meter_ctrl: gate timing, debounce, modes,
// circumference wrap, CLEAR timing, key priority and async reset.
module tb_bike_meter_ctrl;

  localparam int GC = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_up = 1'b0;
  logic       key_clr = 1'b0;
  logic       gate, clr_n, setting;
  logic [3:0] circle;
  logic [1:0] disp_sel;

  int checks = 0;
  int failures = 0;

  bike_meter_ctrl #(
    .GATE_CYCLES(GC),
    .DEB_CYCLES (DC),
    .CIRC_MIN   (1),
    .CIRC_MAX   (15),
    .CIRC_INIT  (14)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_mode(key_mode),
    .key_up  (key_up),
    .key_clr (key_clr),
    .gate    (gate),
    .clr_n   (clr_n),
    .circle  (circle),
    .disp_sel(disp_sel),
    .setting (setting)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which, input int hold);
    case (which)
      0: key_mode = 1'b1;
      1: key_up = 1'b1;
      default: key_clr = 1'b1;
    endcase
    repeat (hold) tick();
    key_mode = 1'b0;
    key_up = 1'b0;
    key_clr = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    logic exp_g;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (gate !== 1'b0) begin
      failures++;
      $display("FAIL rst_gate got=%b exp=0", gate);
    end
    checks++;
    if (clr_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_clr_n got=%b exp=1", clr_n);
    end
    checks++;
    if (circle !== 4'd14) begin
      failures++;
      $display("FAIL rst_circle got=%0d exp=14", circle);
    end
    checks++;
    if (disp_sel !== 2'd0) begin
      failures++;
      $display("FAIL rst_disp got=%0d exp=0", disp_sel);
    end
    checks++;
    if (setting !== 1'b0) begin
      failures++;
      $display("FAIL rst_setting got=%b exp=0", setting);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_g = ((k / GC) % 2) == 1;
      checks++;
      if (gate !== exp_g) begin
        failures++;
        $display("FAIL gate_edge%0d got=%b exp=%b", k, gate, exp_g);
      end
    end
  endtask

  task automatic test_mode();
    logic [1:0] prv [3];
    logic [1:0] nxt [3];
    logic       sn  [3];
    prv = '{2'd0, 2'd1, 2'd2};
    nxt = '{2'd1, 2'd2, 2'd0};
    sn  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      key_mode = 1'b1;
      repeat (6) tick();
      checks++;
      if (disp_sel !== prv[i]) begin
        failures++;
        $display("FAIL mode%0d_early got=%0d exp=%0d", i, disp_sel, prv[i]);
      end
      tick();
      checks++;
      if (disp_sel !== nxt[i] || setting !== sn[i]) begin
        failures++;
        $display("FAIL mode%0d_edge7 got=%0d/%b exp=%0d/%b",
                 i, disp_sel, setting, nxt[i], sn[i]);
      end
      repeat (3) tick();
      key_mode = 1'b0;
      repeat (10) tick();
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 3; i++) begin
      key_mode = 1'b1;
      repeat (2) tick();
      key_mode = 1'b0;
      repeat (2) tick();
      checks++;
      if (disp_sel !== 2'd0) begin
        failures++;
        $display("FAIL bounce%0d got=%0d exp=0", i, disp_sel);
      end
    end
    press(0, 10);
    checks++;
    if (disp_sel !== 2'd1) begin
      failures++;
      $display("FAIL bounce_one got=%0d exp=1", disp_sel);
    end
  endtask

  task automatic test_circle();
    logic [3:0] exp_c [3];
    exp_c = '{4'd15, 4'd1, 4'd2};
    press(0, 10);
    checks++;
    if (disp_sel !== 2'd2 || setting !== 1'b1 || circle !== 4'd14) begin
      failures++;
      $display("FAIL set_entry got=%0d/%b/%0d exp=2/1/14",
               disp_sel, setting, circle);
    end
    for (int i = 0; i < 3; i++) begin
      press(1, 10);
      checks++;
      if (circle !== exp_c[i]) begin
        failures++;
        $display("FAIL circ_up%0d got=%0d exp=%0d", i, circle, exp_c[i]);
      end
    end
    press(0, 10);
    checks++;
    if (disp_sel !== 2'd0 || setting !== 1'b0) begin
      failures++;
      $display("FAIL set_exit got=%0d/%b exp=0/0", disp_sel, setting);
    end
    press(1, 10);
    checks++;
    if (circle !== 4'd2) begin
      failures++;
      $display("FAIL up_in_dist got=%0d exp=2", circle);
    end
  endtask

  task automatic test_clear();
    int   rises;
    logic prev;
    press(0, 10);
    checks++;
    if (disp_sel !== 2'd1) begin
      failures++;
      $display("FAIL clr_pre got=%0d exp=1", disp_sel);
    end
    key_clr = 1'b1;
    repeat (6) tick();
    checks++;
    if (clr_n !== 1'b1) begin
      failures++;
      $display("FAIL clr_early got=%b exp=1", clr_n);
    end
    tick();
    checks++;
    if (clr_n !== 1'b0) begin
      failures++;
      $display("FAIL clr_fall got=%b exp=0", clr_n);
    end
    key_mode = 1'b1;
    prev = gate;
    rises = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (gate && !prev) rises++;
      prev = gate;
      if (k < 8) begin
        checks++;
        if (clr_n !== 1'b0 || disp_sel !== 2'd1) begin
          failures++;
          $display("FAIL clr_hold%0d got=%b/%0d exp=0/1", k, clr_n, disp_sel);
        end
      end
    end
    checks++;
    if (clr_n !== 1'b1) begin
      failures++;
      $display("FAIL clr_rise got=%b exp=1", clr_n);
    end
    checks++;
    if (rises < 1) begin
      failures++;
      $display("FAIL clr_gate_rises got=%0d exp>=1", rises);
    end
    key_clr = 1'b0;
    key_mode = 1'b0;
    repeat (12) tick();
    checks++;
    if (disp_sel !== 2'd1) begin
      failures++;
      $display("FAIL clr_mode_drop got=%0d exp=1", disp_sel);
    end
    press(0, 10);
    checks++;
    if (disp_sel !== 2'd2) begin
      failures++;
      $display("FAIL clr_ret_speed got=%0d exp=2", disp_sel);
    end
    press(0, 10);
    checks++;
    if (disp_sel !== 2'd0) begin
      failures++;
      $display("FAIL clr_back_dist got=%0d exp=0", disp_sel);
    end
  endtask

  task automatic test_priority_reset();
    key_mode = 1'b1;
    key_clr = 1'b1;
    repeat (7) tick();
    checks++;
    if (clr_n !== 1'b0 || disp_sel !== 2'd0) begin
      failures++;
      $display("FAIL prio got=%b/%0d exp=0/0", clr_n, disp_sel);
    end
    repeat (4) tick();
    checks++;
    if (clr_n !== 1'b0) begin
      failures++;
      $display("FAIL prio_mid got=%b exp=0", clr_n);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (clr_n !== 1'b1 || disp_sel !== 2'd0 || setting !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got=%b/%0d/%b exp=1/0/0",
               clr_n, disp_sel, setting);
    end
    checks++;
    if (circle !== 4'd14 || gate !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_circ got=%0d/%b exp=14/0", circle, gate);
    end
    key_mode = 1'b0;
    key_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    checks++;
    if (disp_sel !== 2'd0 || clr_n !== 1'b1) begin
      failures++;
      $display("FAIL post_rst got=%0d/%b exp=0/1", disp_sel, clr_n);
    end
  endtask

  initial begin
    test_reset();
    test_mode();
    test_bounce();
    test_circle();
    test_clear();
    test_priority_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
